// File: rtl/writeback_stage.sv
// Final pipeline stage: registers the memory-stage result, extracts load data, drives the
// register-file write port (also the WB forwarding source) and counts retired instructions.
module writeback_stage #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 5,
    parameter int unsigned FUNCT_WIDTH  = 3,
    parameter int unsigned CNT_WIDTH    = 64,
    parameter int unsigned OPCODE_WIDTH = 11,
    parameter int unsigned LOAD_BIT     = 0
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic                    wb_i_ce,
    input  logic                    wb_i_stall,
    input  logic                    wb_i_flush,
    input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  wb_i_funct3,
    input  logic [AWIDTH-1:0]       wb_i_rd_addr,
    input  logic [DWIDTH-1:0]       wb_i_rd_data,
    input  logic                    wb_i_rd_we,
    input  logic [DWIDTH-1:0]       wb_i_load_data,
    input  logic [1:0]              wb_i_addr_lsb,
    output logic [AWIDTH-1:0]       wb_o_rd_addr,
    output logic [DWIDTH-1:0]       wb_o_rd_data,
    output logic                    wb_o_rd_we,
    output logic                    wb_o_ce,
    output logic                    wb_o_misaligned,
    output logic                    wb_o_illegal,
    output logic [CNT_WIDTH-1:0]    wb_o_instret
);

    logic [AWIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic [DWIDTH-1:0]    rd_data_q, rd_data_d;
    logic                 rd_we_q, rd_we_d;
    logic                 ce_q, ce_d;
    logic                 misaligned_q, misaligned_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] instret_q;

    logic              is_load;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DWIDTH-1:0] load_result;
    logic              load_misaligned;
    logic              load_illegal;
    logic              squash;
    logic              accept;

    // Only the load flag of the one-hot opcode matters here.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^wb_i_opcode;

    assign is_load = wb_i_opcode[LOAD_BIT];
    assign accept  = wb_i_ce && !wb_i_stall && !wb_i_flush;

    always_comb begin
        byte_sel = wb_i_load_data[7:0];
        case (wb_i_addr_lsb)
            2'd1:    byte_sel = wb_i_load_data[15:8];
            2'd2:    byte_sel = wb_i_load_data[23:16];
            2'd3:    byte_sel = wb_i_load_data[31:24];
            default: byte_sel = wb_i_load_data[7:0];
        endcase
        half_sel = wb_i_addr_lsb[1] ? wb_i_load_data[31:16] : wb_i_load_data[15:0];
    end

    always_comb begin
        load_result     = '0;
        load_misaligned = 1'b0;
        load_illegal    = 1'b0;
        case (wb_i_funct3)
            3'b000: load_result = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100: load_result = {{(DWIDTH-8){1'b0}}, byte_sel};
            3'b001: begin
                load_misaligned = wb_i_addr_lsb[0];
                load_result     = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            end
            3'b101: begin
                load_misaligned = wb_i_addr_lsb[0];
                load_result     = {{(DWIDTH-16){1'b0}}, half_sel};
            end
            3'b010: begin
                load_misaligned = (wb_i_addr_lsb != 2'd0);
                load_result     = wb_i_load_data;
            end
            default: load_illegal = 1'b1;
        endcase
    end

    assign squash = is_load && (load_misaligned || load_illegal);

    // Stall holds addr/data but drops every strobe so a held instruction never retires twice.
    always_comb begin
        rd_addr_d    = '0;
        rd_data_d    = '0;
        rd_we_d      = 1'b0;
        ce_d         = 1'b0;
        misaligned_d = 1'b0;
        illegal_d    = 1'b0;
        if (!wb_i_flush && wb_i_stall) begin
            rd_addr_d = rd_addr_q;
            rd_data_d = rd_data_q;
        end else if (accept) begin
            rd_addr_d    = wb_i_rd_addr;
            rd_data_d    = squash ? '0 : (is_load ? load_result : wb_i_rd_data);
            rd_we_d      = wb_i_rd_we && (wb_i_rd_addr != '0) && !squash;
            ce_d         = 1'b1;
            misaligned_d = is_load && load_misaligned;
            illegal_d    = is_load && load_illegal;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            rd_we_q      <= 1'b0;
            ce_q         <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            rd_we_q      <= rd_we_d;
            ce_q         <= ce_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
        end
    end

    // Counts at the capture edge, so instret already includes the instruction shown on wb_o_ce.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            instret_q <= '0;
        end else if (accept) begin
            instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

    assign wb_o_rd_addr    = rd_addr_q;
    assign wb_o_rd_data    = rd_data_q;
    assign wb_o_rd_we      = rd_we_q;
    assign wb_o_ce         = ce_q;
    assign wb_o_misaligned = misaligned_q;
    assign wb_o_illegal    = illegal_q;
    assign wb_o_instret    = instret_q;

endmodule
